// File: rtl/ext_int_arbiter_pkg.sv
// Shared configuration for the external-interrupt arbiter: default source
// count and FSM state encoding.
package ext_int_arbiter_pkg;

    localparam int EXT_INT_SRC_NUM = 8;

    typedef logic [1:0] ext_int_arb_state_t;

    localparam ext_int_arb_state_t IDLE = 2'd0;
    localparam ext_int_arb_state_t REQ  = 2'd1;
    localparam ext_int_arb_state_t HOLD = 2'd2;

endpackage

// File: rtl/ext_int_arbiter_rr_find_first.sv
// Round-robin search: first set candidate at or above (last_grant + 1),
// wrapping to the bottom. The candidates are doubled so that the wrap
// becomes a plain lowest-set-bit search over a masked 2*N vector.
module rr_find_first
    import ext_int_arbiter_pkg::*;
#(
    parameter  int SRC_NUM  = EXT_INT_SRC_NUM,
    localparam int ID_WIDTH = $clog2(SRC_NUM)
) (
    input  logic [SRC_NUM-1:0]  cand,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic                found,
    output logic [ID_WIDTH-1:0] id
);

    logic [2*SRC_NUM-1:0] dbl;
    logic [2*SRC_NUM-1:0] mask;
    logic [2*SRC_NUM-1:0] masked;
    int                   start;

    // Masked priority encode; the upper copy is never masked, so any set
    // candidate is always found even when it sits below the start point.
    always_comb begin
        start  = (int'(last_grant) >= SRC_NUM - 1) ? 0 : int'(last_grant) + 1;
        dbl    = {cand, cand};
        mask   = '0;
        for (int k = 0; k < 2 * SRC_NUM; k++) begin
            mask[k] = (k >= start);
        end
        masked = dbl & mask;
        found  = |cand;
        id     = '0;
        for (int k = 2 * SRC_NUM - 1; k >= 0; k--) begin
            if (masked[k]) begin
                id = ID_WIDTH'(k % SRC_NUM);
            end
        end
    end

endmodule

// File: rtl/ext_int_arbiter.sv
// Round-robin arbiter feeding the single external-interrupt line. Captures
// source rising edges into pending bits, requests one enabled source at a
// time, and returns a one-cycle ack to it once the core acknowledges.
module ext_int_arbiter
    import ext_int_arbiter_pkg::*;
#(
    parameter  int SRC_NUM  = EXT_INT_SRC_NUM,
    localparam int ID_WIDTH = $clog2(SRC_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SRC_NUM-1:0]  src_req,
    output logic [SRC_NUM-1:0]  src_ack,
    input  logic [SRC_NUM-1:0]  cfg_enable,
    output logic                all_intif_int_ext_req,
    input  logic                intif_all_int_ext_ack,
    output logic                arb_claim_valid,
    output logic [ID_WIDTH-1:0] arb_claim_id
);

    ext_int_arb_state_t  state;
    logic [SRC_NUM-1:0]  src_req_q;
    logic [SRC_NUM-1:0]  pending;
    logic [SRC_NUM-1:0]  rise;
    logic [SRC_NUM-1:0]  clr;
    logic [SRC_NUM-1:0]  cand;
    logic [SRC_NUM-1:0]  grant_oh;
    logic [ID_WIDTH-1:0] grant_id;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] sel_id;
    logic                sel_found;
    logic                ack_take;
    logic                grant_enabled;

    assign rise          = src_req & ~src_req_q;
    assign grant_oh      = {{(SRC_NUM-1){1'b0}}, 1'b1} << grant_id;
    assign ack_take      = (state == REQ) && intif_all_int_ext_ack;
    assign clr           = ack_take ? grant_oh : '0;
    assign cand          = pending & cfg_enable;
    // Reduction over the one-hot avoids an out-of-range index when
    // SRC_NUM is not a power of two.
    assign grant_enabled = |(cfg_enable & grant_oh);

    rr_find_first #(
        .SRC_NUM (SRC_NUM)
    ) u_find (
        .cand       (cand),
        .last_grant (last_grant),
        .found      (sel_found),
        .id         (sel_id)
    );

    // Edge capture: a new rising edge wins over the clear of the same bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_req_q <= '0;
            pending   <= '0;
        end else begin
            src_req_q <= src_req;
            pending   <= (pending & ~clr) | rise;
        end
    end

    // Sequencer: pick a winner, hold the request until ack or cancel,
    // then drop the line for one cycle so the core sees it fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(SRC_NUM - 1);
            src_ack    <= '0;
        end else begin
            src_ack <= '0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel_id;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (intif_all_int_ext_ack) begin
                        last_grant <= grant_id;
                        src_ack    <= grant_oh;
                        state      <= HOLD;
                    end else if (!grant_enabled) begin
                        state <= IDLE;
                    end
                end
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign all_intif_int_ext_req = (state == REQ);
    assign arb_claim_valid       = (state == REQ);
    assign arb_claim_id          = grant_id;

endmodule
